// File: rtl/bloom_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// bloom_scan_ctrl_if
// Bundles every signal between the scan controller, the FTL request logic and
// the page comparator block. The clock and reset stay outside the bundle.
//
// Signals:
//   start_valid / start_ready   scan request handshake
//   abort                       cancel a running scan
//   blk_idx, cmp_req            block selection and one-cycle compare strobe
//   match_valid, match_vec      per-page match result for the outstanding compare
//   res_arr, res_cnt            compacted global page numbers and their count
//   done, err, done_ack         completion, timeout flag, consumer acknowledge
//
// Modports:
//   slave   the controller's view
//   master  the view of the surrounding logic (requester, comparator, consumer)
// -----------------------------------------------------------------------------
interface bloom_scan_ctrl_if #(
   parameter int NOB        = 3,
   parameter int PPB        = 8,
   parameter int NOP_WIDTH  = 5,
   parameter int BIDX_WIDTH = 2
);
   logic                          start_valid;
   logic                          start_ready;
   logic                          abort;
   logic [BIDX_WIDTH-1:0]         blk_idx;
   logic                          cmp_req;
   logic                          match_valid;
   logic [PPB-1:0]                match_vec;
   logic [NOP_WIDTH*NOB*PPB-1:0]  res_arr;
   logic [NOP_WIDTH-1:0]          res_cnt;
   logic                          done;
   logic                          err;
   logic                          done_ack;

   modport slave (
      input  start_valid, abort, match_valid, match_vec, done_ack,
      output start_ready, blk_idx, cmp_req, res_arr, res_cnt, done, err
   );

   modport master (
      output start_valid, abort, match_valid, match_vec, done_ack,
      input  start_ready, blk_idx, cmp_req, res_arr, res_cnt, done, err
   );
endinterface

// File: rtl/bloom_scan_ctrl.sv
// -----------------------------------------------------------------------------
// bloom_scan_ctrl
// Sequencer for the block-serial bit-pattern comparison datapath. A scan
// request steps the block index through all NOB blocks, issues one compare
// per block, and compacts the global page numbers of every matching page, in
// ascending order, into res_arr with the count in res_cnt.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous reset, active-low
//   bus   bloom_scan_ctrl_if.slave (handshake, compare strobe, results)
//
// Parameters:
//   NOB         blocks per scan
//   PPB         pages per block
//   NOP_WIDTH   width of one global page number (2^NOP_WIDTH >= NOB*PPB)
//   BIDX_WIDTH  block index width
//   TIMEOUT     WAIT cycles without match_valid before the error exit
// -----------------------------------------------------------------------------
module bloom_scan_ctrl #(
   parameter int NOB        = 3,
   parameter int PPB        = 8,
   parameter int NOP_WIDTH  = 5,
   parameter int BIDX_WIDTH = 2,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   bloom_scan_ctrl_if.slave      bus
);

   localparam int NENT  = NOB * PPB;
   localparam int RES_W = NOP_WIDTH * NENT;
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [BIDX_WIDTH-1:0] LAST_BLK = BIDX_WIDTH'(NOB - 1);
   localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                 state, state_nx;
   logic [BIDX_WIDTH-1:0]  blk_idx, blk_nx;
   logic [RES_W-1:0]       res_arr, arr_nx, arr_merged;
   logic [NOP_WIDTH-1:0]   res_cnt, cnt_nx, cnt_merged;
   logic                   err, err_nx;
   logic [TMO_W-1:0]       tmo_cnt, tmo_nx;
   int                     slot;

   // Global page number of page j in block b; fits NOP_WIDTH by construction.
   function automatic logic [NOP_WIDTH-1:0] page_num(input logic [BIDX_WIDTH-1:0] b,
                                                     input int j);
      return NOP_WIDTH'(int'(b) * PPB + j);
   endfunction

   // Compaction: each set bit of match_vec, in ascending page order, lands in
   // the next free slot after the entries already collected. Slots are matched
   // against constant entry indices so every write is a fixed-position select.
   always_comb begin
      arr_merged = res_arr;
      slot       = int'(res_cnt);
      for (int j = 0; j < PPB; j++) begin
         if (bus.match_vec[j]) begin
            for (int k = 0; k < NENT; k++) begin
               if (k == slot) begin
                  arr_merged[NOP_WIDTH*k +: NOP_WIDTH] = page_num(blk_idx, j);
               end
            end
            slot = slot + 1;
         end
      end
      cnt_merged = NOP_WIDTH'(slot);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         blk_idx <= '0;
         res_arr <= '0;
         res_cnt <= '0;
         err     <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nx;
         blk_idx <= blk_nx;
         res_arr <= arr_nx;
         res_cnt <= cnt_nx;
         err     <= err_nx;
         tmo_cnt <= tmo_nx;
      end
   end

   always_comb begin
      state_nx        = state;
      blk_nx          = blk_idx;
      arr_nx          = res_arr;
      cnt_nx          = res_cnt;
      err_nx          = err;
      tmo_nx          = tmo_cnt;
      bus.start_ready = 1'b0;
      bus.cmp_req     = 1'b0;
      bus.done        = 1'b0;

      case (state)
         IDLE: begin
            bus.start_ready = 1'b1;
            if (bus.start_valid) begin
               arr_nx   = '0;
               cnt_nx   = '0;
               blk_nx   = '0;
               err_nx   = 1'b0;
               state_nx = ISSUE;
            end
         end

         ISSUE: begin
            bus.cmp_req = 1'b1;
            tmo_nx      = '0;
            if (bus.abort) begin
               arr_nx   = '0;
               cnt_nx   = '0;
               blk_nx   = '0;
               state_nx = IDLE;
            end else begin
               state_nx = WAIT;
            end
         end

         WAIT: begin
            // abort wins over a simultaneous match_valid
            if (bus.abort) begin
               arr_nx   = '0;
               cnt_nx   = '0;
               blk_nx   = '0;
               state_nx = IDLE;
            end else if (bus.match_valid) begin
               arr_nx = arr_merged;
               cnt_nx = cnt_merged;
               if (blk_idx == LAST_BLK) begin
                  state_nx = DONE;
               end else begin
                  blk_nx   = blk_idx + BIDX_WIDTH'(1);
                  state_nx = ISSUE;
               end
            end else if (tmo_cnt == TMO_LAST) begin
               // this WAIT cycle is the TIMEOUT-th without a response
               err_nx   = 1'b1;
               state_nx = DONE;
            end else begin
               tmo_nx = tmo_cnt + TMO_W'(1);
            end
         end

         DONE: begin
            bus.done = 1'b1;
            if (bus.done_ack) begin
               state_nx = IDLE;
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.blk_idx = blk_idx;
   assign bus.res_arr = res_arr;
   assign bus.res_cnt = res_cnt;
   assign bus.err     = err;

endmodule
